// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit -- sequential unsigned shift-add multiplier with HI/LO registers and a registered read port.
// Revision 1.0
`default_nettype none

module multu_hilo_unit #(
  parameter logic [5:0] MULTU = 6'd25,
  parameter logic [5:0] HI    = 6'd61,
  parameter logic [5:0] LO    = 6'd60,
  parameter int         WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut,
  output logic [WIDTH-1:0] dataOut
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     hi_reg;
  logic [WIDTH-1:0]     lo_reg;
  logic [WIDTH-1:0]     read_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [2*WIDTH-1:0]   sum;

  // Post-add product of the current iteration; also the final product on the last one.
  assign sum = mplier[0] ? (product + mcand) : product;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      mcand    <= '0;
      mplier   <= '0;
      product  <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      read_reg <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      // Reads sample HI/LO before any completion write on this same edge.
      if (signal == HI) begin
        read_reg <= hi_reg;
      end else if (signal == LO) begin
        read_reg <= lo_reg;
      end

      case (state)
        IDLE: begin
          if (signal == MULTU) begin
            mcand    <= {{WIDTH{1'b0}}, dataA};
            mplier   <= dataB;
            product  <= '0;
            count    <= '0;
            state    <= RUN;
            busy_reg <= 1'b1;
          end
        end
        RUN: begin
          product <= sum;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          count   <= count + CW'(1);
          if (count == LAST) begin
            hi_reg   <= sum[2*WIDTH-1:WIDTH];
            lo_reg   <= sum[WIDTH-1:0];
            state    <= IDLE;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign hiOut   = hi_reg;
  assign loOut   = lo_reg;
  assign dataOut = read_reg;

endmodule

`default_nettype wire

// File: tb/tb_multu_hilo_unit.sv
// tb_multu_hilo_unit -- scoreboard bench for multu_hilo_unit.
// Revision 1.0
`default_nettype none

module tb_multu_hilo_unit;

  localparam logic [5:0] C_MULTU = 6'd25;
  localparam logic [5:0] C_HI    = 6'd61;
  localparam logic [5:0] C_LO    = 6'd60;
  localparam logic [5:0] C_NOP   = 6'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  signal = C_NOP;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic        busy;
  logic        done;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic [31:0] dataOut;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;
  int pass_cnt = 0;
  int total_cnt = 0;

  multu_hilo_unit dut (
    .clk(clk), .reset(reset), .signal(signal), .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .hiOut(hiOut), .loOut(loOut), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a MULTU for one edge and push the expected product.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
    logic [63:0] p;
    signal = C_MULTU;
    dataA  = a;
    dataB  = b;
    p = {32'b0, a} * {32'b0, b};
    if (push) sb.push_back('{hi: p[63:32], lo: p[31:0]});
    tick();
    signal = C_NOP;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL issue_busy: busy=%b expected 1", busy);
    else pass_cnt++;
  endtask

  // Wait (bounded) for done, then pop and compare HI/LO against the scoreboard.
  task automatic wait_done(output int busy_cycles);
    exp_t e;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) break;
      tick();
    end
    total_cnt++;
    if (done !== 1'b1) begin
      $display("FAIL done_timeout: done=%b expected 1 within 40 cycles", done);
    end else begin
      pass_cnt++;
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL sb_empty: queue size=0 expected >0");
      end else begin
        e = sb.pop_front();
        model_hi = e.hi;
        model_lo = e.lo;
        if (hiOut !== e.hi || loOut !== e.lo)
          $display("FAIL result: hi=%h lo=%h expected hi=%h lo=%h", hiOut, loOut, e.hi, e.lo);
        else pass_cnt++;
      end
    end
  endtask

  task automatic read_reg(input logic [5:0] code, input logic [31:0] exp_val, input string name);
    signal = code;
    tick();
    signal = C_NOP;
    total_cnt++;
    if (dataOut !== exp_val) $display("FAIL %s: dataOut=%h expected %h", name, dataOut, exp_val);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00 || hiOut !== 0 || loOut !== 0 || dataOut !== 0)
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h out=%h expected all 0",
               busy, done, hiOut, loOut, dataOut);
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int bc;
    issue(32'd7, 32'd6, 1'b1);
    wait_done(bc);
    total_cnt++;
    if (bc != 32) $display("FAIL busy_length: busy cycles=%0d expected 32", bc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL done_pulse: done=%b expected 0", done);
    else pass_cnt++;
    read_reg(C_LO, 32'h0000_002A, "read_lo_basic");
  endtask

  task automatic test_max();
    int bc;
    logic [31:0] old_hi;
    old_hi = model_hi;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    signal = C_HI;
    wait_done(bc);
    // The read taken on the completion edge still reflects the old HI.
    total_cnt++;
    if (dataOut !== old_hi) $display("FAIL completion_read: dataOut=%h expected %h", dataOut, old_hi);
    else pass_cnt++;
    read_reg(C_HI, 32'hFFFF_FFFE, "read_hi_max");
  endtask

  task automatic test_back_to_back();
    int bc;
    issue(32'h1234_5678, 32'd0, 1'b1);
    wait_done(bc);
    issue(32'h0001_0000, 32'h0001_0000, 1'b1);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL b2b_done_fall: done=%b expected 0", done);
    else pass_cnt++;
    wait_done(bc);
    total_cnt++;
    if (bc != 32) $display("FAIL b2b_busy_length: busy cycles=%0d expected 32", bc);
    else pass_cnt++;
  endtask

  task automatic test_ignore_during_run();
    int bc;
    logic [31:0] old_hi;
    old_hi = model_hi;
    issue(32'd3, 32'd5, 1'b1);
    tick();
    tick();
    issue(32'd9, 32'd9, 1'b0);
    read_reg(C_HI, old_hi, "stale_hi_read");
    wait_done(bc);
    tick();
    total_cnt++;
    if (busy !== 1'b0 || sb.size() != 0)
      $display("FAIL no_queue: busy=%b queue=%0d expected busy 0 queue 0", busy, sb.size());
    else pass_cnt++;
    read_reg(C_LO, 32'd15, "read_lo_ignore");
  endtask

  task automatic test_reset_mid_run();
    int bc;
    issue(32'd100, 32'd200, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done} !== 2'b00 || hiOut !== 0 || loOut !== 0 || dataOut !== 0)
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h out=%h expected all 0",
               busy, done, hiOut, loOut, dataOut);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    tick();
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL post_reset_idle: busy=%b done=%b expected 00", busy, done);
    else pass_cnt++;
    issue(32'd2, 32'd3, 1'b1);
    wait_done(bc);
    tick();
  endtask

  task automatic test_other_codes();
    logic [31:0] old_out;
    read_reg(C_LO, 32'd6, "read_lo_after_reset");
    old_out = dataOut;
    for (int i = 0; i < 6; i++) begin
      signal = (i < 3) ? 6'd32 : 6'd2;
      dataA  = $urandom;
      dataB  = $urandom;
      tick();
      total_cnt++;
      if (busy !== 1'b0 || done !== 1'b0 || dataOut !== old_out || hiOut !== model_hi || loOut !== model_lo)
        $display("FAIL other_code_%0d: busy=%b done=%b out=%h hi=%h lo=%h expected 0 0 %h %h %h",
                 i, busy, done, dataOut, hiOut, loOut, old_out, model_hi, model_lo);
      else pass_cnt++;
    end
    signal = C_NOP;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_ignore_during_run();
    test_reset_mid_run();
    test_other_codes();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
